// File: rtl/muldiv_pkg.sv
// Shared M-extension constants: op encodings, FSM states and sizing helpers for the mul/div unit.
package muldiv_pkg;

   localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
   localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
   localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
   localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
   localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
   localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
   localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
   localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_POST,
      ST_DONE
   } muldiv_state_e;

   function automatic logic [63:0] most_neg(input int unsigned xlen);
      return 64'd1 << (xlen - 1);
   endfunction

   function automatic int unsigned div_iter(input int unsigned xlen, input int unsigned bpc);
      return xlen / bpc;
   endfunction

   function automatic logic op_rs1_signed(input logic [2:0] op);
      return op inside {MULDIV_OP_MUL, MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_DIV, MULDIV_OP_REM};
   endfunction

   function automatic logic op_rs2_signed(input logic [2:0] op);
      return op inside {MULDIV_OP_MUL, MULDIV_OP_MULH, MULDIV_OP_DIV, MULDIV_OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_iter_divider.sv
// Unsigned restoring divider retiring DIV_BITS_PER_CYCLE quotient bits per cycle.
// done pulses for one cycle after the last iteration; outputs hold until the next start.
module muldiv_iter_divider
   import muldiv_pkg::*;
#(
   parameter int XLEN               = 32,
   parameter int DIV_BITS_PER_CYCLE = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start,
   input  logic            kill,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            done
);

   localparam int unsigned ITER = div_iter(XLEN, DIV_BITS_PER_CYCLE);
   localparam int CW = $clog2(ITER + 1);

   logic [XLEN-1:0] rem_q, quo_q, dvs_q;
   logic [XLEN-1:0] rem_n, quo_n;
   logic [XLEN:0]   shifted;
   logic [CW-1:0]   cnt_q;
   logic            busy_q, done_q;

   // quo_q doubles as the dividend shift register: bits leave at the top, quotient bits enter at the bottom
   always_comb begin
      rem_n   = rem_q;
      quo_n   = quo_q;
      shifted = '0;
      for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
         shifted = {rem_n, quo_n[XLEN-1]};
         quo_n   = {quo_n[XLEN-2:0], 1'b0};
         if (shifted >= {1'b0, dvs_q}) begin
            shifted  = shifted - {1'b0, dvs_q};
            quo_n[0] = 1'b1;
         end
         rem_n = shifted[XLEN-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (kill) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start) begin
         rem_q  <= '0;
         quo_q  <= dividend;
         dvs_q  <= divisor;
         cnt_q  <= CW'(ITER);
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (busy_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign done      = done_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV M-extension multiply/divide unit: pipelined multiplier, iterative divider, one-cycle
// fast paths (div-by-zero, overflow, small dividend, DIV/REM pair cache), valid/ready with flush.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN               = 32,
   parameter int MUL_LATENCY        = 4,
   parameter int DIV_BITS_PER_CYCLE = 2,
   parameter int DIV_CACHE_EN       = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] num1_i,
   input  logic [XLEN-1:0] num2_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o
);

   localparam logic [63:0]     MOST_NEG64 = most_neg(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG   = MOST_NEG64[XLEN-1:0];
   localparam int MCW = $clog2(MUL_LATENCY + 1) + 1;

   muldiv_state_e state_q, state_d;

   logic            accept, neg1, neg2, is_div_in, is_rem_in, div_sgn_in;
   logic            div_zero, div_ovf, cache_hit, small_div, fast;
   logic [XLEN-1:0] abs1, abs2, fast_res;

   logic [1:0]      op_q;
   logic            neg_q, neg_rem_q, div_sgn_q, fast_q;
   logic [XLEN-1:0] a_q, b_q, num1_q, num2_q, fast_res_q;
   logic [MCW-1:0]  mul_cnt;

   logic            c_vld, c_sgn;
   logic [XLEN-1:0] c_a, c_b, c_quo, c_rem;

   logic            div_start, div_done;
   logic [XLEN-1:0] div_quo, div_rem, q_fix, r_fix, div_res;
   logic [2*XLEN-1:0] mul_prod, prod_fix;
   logic [XLEN-1:0] mul_res, done_res, res_q;

   assign in_ready_o  = (state_q == ST_IDLE) && !rst_i;
   assign accept      = in_valid_i && in_ready_o && !flush_i;
   assign out_valid_o = (state_q == ST_DONE);
   assign result_o    = res_q;

   assign neg1       = op_rs1_signed(op_i) & num1_i[XLEN-1];
   assign neg2       = op_rs2_signed(op_i) & num2_i[XLEN-1];
   assign abs1       = neg1 ? -num1_i : num1_i;
   assign abs2       = neg2 ? -num2_i : num2_i;
   assign is_div_in  = op_i[2];
   assign is_rem_in  = op_i[1];
   assign div_sgn_in = ~op_i[0];

   assign div_zero  = (num2_i == '0);
   assign div_ovf   = div_sgn_in && (num1_i == MOST_NEG) && (num2_i == '1);
   assign cache_hit = (DIV_CACHE_EN != 0) && c_vld && (c_a == num1_i) && (c_b == num2_i)
                      && (c_sgn == div_sgn_in);
   assign small_div = (abs1 < abs2);
   assign fast      = is_div_in && (div_zero || div_ovf || cache_hit || small_div);

   always_comb begin
      fast_res = '0;
      if (div_zero)       fast_res = is_rem_in ? num1_i : '1;
      else if (div_ovf)   fast_res = is_rem_in ? '0 : num1_i;
      else if (cache_hit) fast_res = is_rem_in ? c_rem : c_quo;
      else                fast_res = is_rem_in ? num1_i : '0;
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         op_q       <= op_i[1:0];
         neg_q      <= neg1 ^ neg2;
         neg_rem_q  <= neg1;
         div_sgn_q  <= div_sgn_in;
         a_q        <= abs1;
         b_q        <= abs2;
         num1_q     <= num1_i;
         num2_q     <= num2_i;
         fast_res_q <= fast_res;
      end
   end

   // Product of the captured magnitudes; sign is restored after the last stage
   for (genvar i = 0; i < MUL_LATENCY; i++) begin : g_mul
      logic [2*XLEN-1:0] prod;
      if (i == 0) begin : g_first
         always_ff @(posedge clk_i) prod <= {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
      end else begin : g_next
         always_ff @(posedge clk_i) prod <= g_mul[i-1].prod;
      end
   end

   assign mul_prod = g_mul[MUL_LATENCY-1].prod;
   assign prod_fix = neg_q ? -mul_prod : mul_prod;
   assign mul_res  = (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

   assign div_start = accept && is_div_in && !fast;

   muldiv_iter_divider #(
      .XLEN               (XLEN),
      .DIV_BITS_PER_CYCLE (DIV_BITS_PER_CYCLE)
   ) u_div (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start     (div_start),
      .kill      (flush_i),
      .dividend  (abs1),
      .divisor   (abs2),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   assign q_fix   = neg_q ? -div_quo : div_quo;
   assign r_fix   = neg_rem_q ? -div_rem : div_rem;
   assign div_res = op_q[1] ? r_fix : q_fix;

   // Fast-path divides park in DIV for one cycle so the result lands after T+1
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = is_div_in ? ST_DIV : ST_MUL;
         ST_MUL:  if (mul_cnt == MCW'(MUL_LATENCY)) state_d = ST_DONE;
         ST_DIV: begin
            if (fast_q)        state_d = ST_DONE;
            else if (div_done) state_d = ST_POST;
         end
         ST_POST: state_d = ST_DONE;
         ST_DONE: if (out_ready_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush_i) state_d = ST_IDLE;
   end

   always_comb begin
      done_res = fast_res_q;
      case (state_q)
         ST_MUL:  done_res = mul_res;
         ST_POST: done_res = div_res;
         default: done_res = fast_res_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         mul_cnt <= '0;
         fast_q  <= 1'b0;
         c_vld   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            mul_cnt <= '0;
            fast_q  <= fast;
         end else if (state_q == ST_MUL) begin
            mul_cnt <= mul_cnt + MCW'(1);
         end
         if (state_d == ST_DONE && state_q != ST_DONE) res_q <= done_res;
         if (flush_i || (state_q == ST_MUL && state_d == ST_DONE)) begin
            c_vld <= 1'b0;
         end else if (state_q == ST_POST) begin
            c_vld <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == ST_POST) begin
         c_a   <= num1_q;
         c_b   <= num2_q;
         c_sgn <= div_sgn_q;
         c_quo <= q_fix;
         c_rem <= r_fix;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32, MUL_LATENCY=4, radix-4 divider): results and latencies.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  op;
   logic [31:0] num1, num2;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] exp_q[$];
   int          lat_q[$];

   logic [31:0] rx, ry, ra, rb, rt;
   logic [63:0] rp;
   int          vcnt;

   muldiv_unit #(
      .XLEN               (32),
      .MUL_LATENCY        (4),
      .DIV_BITS_PER_CYCLE (2),
      .DIV_CACHE_EN       (1)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .op_i        (op),
      .num1_i      (num1),
      .num2_i      (num2),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .flush_i     (flush),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      for (int k = 0; k < 60 && !in_ready; k++) @(negedge clk);
      if (!in_ready) check({tag, "_ready"}, in_ready, 1);
   endtask

   // Drives one request, then times and checks the response against the scoreboard head
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int t0;
      int lat;
      bit seen;
      logic [31:0] e;
      int el;
      exp_q.push_back(exp_res);
      lat_q.push_back(exp_lat);
      wait_ready(tag);
      op = o; num1 = a; num2 = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      t0 = cyc;
      seen = 1'b0;
      lat = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
         if (out_valid) begin
            seen = 1'b1;
            lat = cyc - t0;
         end else begin
            @(negedge clk);
         end
      end
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      check({tag, "_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_res"}, result, e);
         check({tag, "_lat"}, lat, el);
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; op = '0; num1 = '0; num2 = '0;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);

      run_op("mulh_m1x2",   MULDIV_OP_MULH,   32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 5);
      run_op("mul_m1x2",    MULDIV_OP_MUL,    32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 5);
      run_op("mulhu_max",   MULDIV_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
      run_op("mulhsu_max",  MULDIV_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
      run_op("mulh_neg2",   MULDIV_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 5);

      run_op("div_m7_2",    MULDIV_OP_DIV,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 18);
      run_op("rem_m7_2",    MULDIV_OP_REM,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1);
      run_op("divu_by0",    MULDIV_OP_DIVU, 32'h1234, 32'h0, 32'hFFFFFFFF, 1);
      run_op("remu_by0",    MULDIV_OP_REMU, 32'h1234, 32'h0, 32'h1234, 1);
      run_op("rem_ovf",     MULDIV_OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
      run_op("div_ovf",     MULDIV_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("divu_small",  MULDIV_OP_DIVU, 32'd5, 32'd9, 32'h0, 1);
      run_op("remu_small",  MULDIV_OP_REMU, 32'd5, 32'd9, 32'd5, 1);
      run_op("divu_100_7",  MULDIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 18);
      run_op("remu_100_7",  MULDIV_OP_REMU, 32'd100, 32'd7, 32'd2, 1);
      run_op("div_100_m7",  MULDIV_OP_DIV,  32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 18);
      run_op("rem_m100_7",  MULDIV_OP_REM,  32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 18);

      for (int i = 0; i < 4; i++) begin
         rx = $urandom; ry = $urandom;
         rp = {32'b0, rx} * {32'b0, ry};
         run_op("rnd_mul", MULDIV_OP_MUL, rx, ry, rp[31:0], 5);
         rb = $urandom | 32'h1; ra = $urandom;
         if (ra < rb) begin rt = ra; ra = rb; rb = rt; end
         run_op("rnd_divu", MULDIV_OP_DIVU, ra, rb, ra / rb, 18);
         run_op("rnd_remu", MULDIV_OP_REMU, ra, rb, ra % rb, 1);
      end

      // Backpressure: result must hold while the consumer stalls
      out_ready = 1'b0;
      exp_q.push_back(32'd21);
      wait_ready("bp");
      op = MULDIV_OP_MUL; num1 = 32'd3; num2 = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      check("bp_seen", out_valid, 1);
      check("bp_res", result, exp_q.pop_front());
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_hold_res", result, 32'd21);
         check("bp_hold_vld", out_valid, 1);
         check("bp_hold_rdy", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_vld", out_valid, 0);
      check("bp_release_rdy", in_ready, 1);

      run_op("fl_pre_div", MULDIV_OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 18);
      wait_ready("fl");
      op = MULDIV_OP_DIV; num1 = 32'd9; num2 = 32'd2; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("fl_vld", out_valid, 0);
      check("fl_rdy", in_ready, 1);
      vcnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid) vcnt++;
         @(negedge clk);
      end
      check("fl_no_output", vcnt, 0);
      run_op("fl_div_recalc", MULDIV_OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 18);
      run_op("fl_rem_9_2",    MULDIV_OP_REM, 32'd9, 32'd2, 32'd1, 18);
      run_op("fl_div_9_2",    MULDIV_OP_DIV, 32'd9, 32'd2, 32'd4, 1);

      wait_ready("rst_mul");
      op = MULDIV_OP_MUL; num1 = 32'd3; num2 = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstm_rdy", in_ready, 0);
      check("rstm_vld", out_valid, 0);
      check("rstm_res", result, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rstm_after_rdy", in_ready, 1);
      check("rstm_after_vld", out_valid, 0);
      check("rstm_after_res", result, 0);
      vcnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (out_valid) vcnt++;
         @(negedge clk);
      end
      check("rstm_no_output", vcnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised successor to the fixed-latency 32-bit mul/div unit: RV M-extension multiply/divide with generic XLEN.
- Multiplier latency is configurable; the iterative divider is radix-2 or radix-4.
- Uses valid/ready handshakes on both sides and supports pipeline flush.
- Adds one-cycle fast paths: divide-by-zero, signed overflow, small dividend, and a DIV/REM pair cache.
- Sits in the execute stage beside the integer ALU; the top-level ALU selects it via its section code.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_LATENCY, 4, register stages after operand capture in the multiply path (>=1)
DIV_BITS_PER_CYCLE, 2, quotient bits retired per divider cycle (1 or 2)
DIV_CACHE_EN, 1, enables the DIV/REM operand-pair cache

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
op_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
num1_i  in  XLEN  rs1 operand
num2_i  in  XLEN  rs2 operand
in_valid_i  in  1  request valid
in_ready_o  out  1  unit can accept a request
flush_i  in  1  kill in-flight op (pipeline flush)
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
result_o  out  XLEN  result, stable while out_valid_o && !out_ready_i

Behaviour:
- Reset: state IDLE; out_valid_o=0; result_o=0; cache invalid; in_ready_o=0 while rst_i is high, 1 on the first cycle after.
- Accept when in_valid_i && in_ready_o && !flush_i at edge T.
  - At the accept edge, register op, sign flags, absolute operands, result-negate flag and the special-case flags.
  - Signedness: MUL/MULH/DIV/REM both signed; MULHSU rs1 only; others unsigned.
- in_ready_o = (state==IDLE) && !rst_i. Any new accept starts from IDLE, so there is no back-to-back accept from DONE.
- States:
  - IDLE -> MUL, DIV, or DONE (fast path).
  - MUL -> DONE after MUL_LATENCY cycles.
  - DIV -> POST after N = XLEN/DIV_BITS_PER_CYCLE iterations.
  - POST -> DONE.
  - DONE -> IDLE on out_ready_i.
- Multiply path:
  - Unsigned 2*XLEN product of the absolute values, pipelined; two's-complement negate if the sign flip is set.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - out_valid_o rises after edge T+MUL_LATENCY+1.
- Divide path (normal): restoring iterations in sub-module; POST applies sign correction.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - out_valid_o rises after edge T+N+2 (T+18 for XLEN=32, radix-4).
- Fast paths: DONE after edge T+1, priority in this order:
  1. Divisor 0: quotient all-ones, remainder num1_i.
  2. Signed overflow (DIV/REM, num1 = most-negative, num2 = -1): quotient num1_i, remainder 0.
  3. Cache hit: DIV_CACHE_EN, previous completed op was a divide with identical num1/num2 and identical signedness (any of DIV/DIVU/REM/REMU).
  4. |num1| < |num2| (unsigned compare of abs values): quotient 0, remainder num1_i.
- Cache:
  - Stores operands, signedness, final quotient and final remainder on every completed normal-path divide.
  - Invalidated by rst_i, flush_i, or any completed multiply.
- flush_i:
  - From any state -> IDLE next edge; out_valid_o=0 next cycle; divider iteration counter cleared; cache invalidated.
  - Flush has priority over accept and over out_ready_i in the same cycle.
- Result register is loaded on entry to DONE only; it is held unchanged through backpressure.

Decomposition:
- Shared package (the team's M-extension constants):
  - op encodings MULDIV_OP_*.
  - state encodings.
  - helper constants: MOST_NEG(XLEN), DIV_ITER = XLEN/DIV_BITS_PER_CYCLE.
- One sub-module: muldiv_iter_divider (clk_i, rst_i, start, kill, unsigned dividend/divisor XLEN, quotient/remainder, done).
  - Radix per DIV_BITS_PER_CYCLE; done pulses one cycle after the last iteration.
- Multiplier pipeline stays inline as a generate-for register chain.

Test Plan (XLEN=32, MUL_LATENCY=4, DIV_BITS_PER_CYCLE=2):
- MULH 0xFFFFFFFF x 0x00000002 (-1 x 2), out_ready_i=1 -> out_valid_o after edge T+5, result 0xFFFFFFFF; MUL same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 0x00000002 (-7/2) -> valid after T+18, result 0xFFFFFFFD; next REM with the same operands -> valid after T+1 (cache hit), result 0xFFFFFFFF.
- DIVU x / 0 with num1=0x1234 -> T+1, 0xFFFFFFFF; REM 0x80000000 / 0xFFFFFFFF -> T+1, result 0; DIV same operands -> 0x80000000.
- DIVU 5 / 9 -> T+1, result 0; REMU 5 / 9 -> 5.
- Hold out_ready_i=0 for 10 cycles after a MUL 3x7 -> result_o stays 21, out_valid_o stays 1, in_ready_o stays 0; release -> IDLE next edge.
- Assert flush_i mid-DIV (cycle T+6), then issue REM with the same operands -> no output for the killed op, REM takes the full T+18 path (cache invalidated). Repeat with rst_i mid-MUL -> all outputs return to reset values.
